uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
RTL UART receiver that consumes the serial tx line driven by a device agent BFM and produces parallel bytes with error status. It sits directly downstream of the UART interface's tx/rx wiring and is the first DUT-side stage of the receive path. The block uses 16x oversampling with a programmable baud divisor, configurable frame format, and a valid/ready output handshake.

Parameters:
OVERSAMPLE, 16, samples per bit; fixed power of two, counter width log2(OVERSAMPLE)
DIV_WIDTH, 16, width of baud divisor input
SYNC_STAGES, 2, rx input synchronizer depth (minimum 2)

Ports:
pclk  input  1  system clock
areset  input  1  asynchronous reset, active-high
rx  input  1  serial line, idle high
baud_div  input  DIV_WIDTH  oversample tick every baud_div+1 pclk cycles
data_bits  input  2  0=5, 1=6, 2=7, 3=8 data bits
parity_en  input  1  parity bit present
parity_odd  input  1  1=odd parity, 0=even parity
stop2  input  1  1=two stop bits
rx_data  output  8  received byte, LSB-aligned, unused MSBs zero
rx_valid  output  1  rx_data/status valid
rx_ready  input  1  consumer accepts when rx_valid && rx_ready
parity_err  output  1  parity mismatch for the presented byte
frame_err  output  1  stop bit sampled low for the presented byte
overrun  output  1  sticky: a frame completed while rx_valid was pending
err_clr  input  1  single-cycle pulse clears overrun

Behaviour:
- Reset (async, active-high): synchronizer flops = 1, FSM = IDLE, all counters 0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0.
- Config inputs are sampled only in IDLE. Changing them mid-frame has no effect until the next frame.
- Tick generator: free-running counter 0..baud_div. A tick pulses when the counter wraps. baud_div=0 gives a tick every cycle.
- All FSM actions occur on ticks only. A sample counter s counts 0..15 within each bit.
- Bit value = majority of the synchronized rx at s=7, 8 and 9. The decision is taken at s=9.
- FSM states and transitions:
  - IDLE: synchronized rx == 0 on a tick -> START, s=0.
  - START: at s=9, if the voted value is 1 (false start) -> IDLE; otherwise at s=15 -> DATA.
  - DATA: bit index 0..N-1, LSB first, shifted into rx_data position. After the last bit -> PARITY if parity_en, else STOP.
  - PARITY: the received bit is XORed with the data bits. Expected result: even -> 0, odd -> 1. A mismatch sets the pending parity_err.
  - STOP: first stop bit decided at s=9.
    - If 0: frame_err pending, complete the frame, -> BREAK_WAIT.
    - If 1 and stop2: sample the second stop bit the same way. A 0 also flags frame_err.
    - Completion occurs at s=9 of the final stop bit. The FSM then returns to IDLE, so a new start edge can be detected within that bit's remaining half.
  - BREAK_WAIT: stay until synchronized rx == 1, then -> IDLE. A low line does not retrigger.
- Completion with rx_valid==0 (or an accept in the same cycle): the next cycle loads rx_data, parity_err and frame_err, and sets rx_valid=1.
- Completion with rx_valid==1 and no accept: the new frame is dropped, the old data is held, and overrun is set.
- overrun is cleared only by err_clr. If err_clr and an overrun event occur in the same cycle, set wins.
- rx_valid falls the cycle after the handshake. The output fields are stable while rx_valid=1.
- Latency: rx_valid rises 1 pclk after the completion tick.
- Reset mid-frame aborts the frame with no output. After reset release the line must be seen high then low before a new frame starts.

Decomposition:
- Package uart_rx_pkg holds:
  - rx_state_e enum: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - data_bits encoding constants.
  - OVERSAMPLE_DEF and MID_SAMPLE=9 localparams.
- Sub-module uart_baud_tick: the tick generator, with pclk, areset, baud_div and tick ports. It is reused by the planned transmitter.

Test Plan:
- Frame 0x55, 8N1, baud_div=3: rx_data=0x55 and rx_valid asserted at the expected tick count; parity_err=0, frame_err=0. Hold rx_ready low 5 cycles: outputs stay stable.
- Frame 0xA3, 8E1 with correct parity bit 0, then the same frame with parity bit 1: first gives parity_err=0, second gives parity_err=1, rx_data=0xA3 both times.
- Frame 0x1F, 5N2 with the second stop bit forced low: rx_data=0x1F, frame_err=1. The FSM waits in BREAK_WAIT while rx stays low for 3 bit times, and emits no spurious frame.
- Low glitch of 4 oversample ticks on an idle line: false start, no rx_valid, FSM back in IDLE.
- Two back-to-back 0x11 and 0x22 frames with rx_ready=0: first byte held, overrun=1. An err_clr pulse clears overrun while rx_data stays 0x11.
- areset asserted mid-DATA of a 0x3C frame: outputs 0 immediately. After release, frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Frame-format encodings and oversampling defaults live here.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_e;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_SAMPLE     = 9;

    // Index of the final data bit for a data_bits code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
        logic [2:0] idx;
        idx = 3'd7;
        unique case (db)
            DBITS_5: idx = 3'd4;
            DBITS_6: idx = 3'd5;
            DBITS_7: idx = 3'd6;
            DBITS_8: idx = 3'd7;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every baud_div+1 clocks.
// Shared between the receiver and the transmitter.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 pclk,
    input  logic                 areset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // >= keeps the counter bounded if baud_div shrinks mid-count
    assign tick = (cnt >= baud_div);

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 16x oversampling UART receiver with majority-vote bit decisions,
// configurable frame format and a valid/ready byte output.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 pclk,
    input  logic                 areset,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           data_bits,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_V0   = SW'(MID_SAMPLE - 2);
    localparam logic [SW-1:0] S_V1   = SW'(MID_SAMPLE - 1);
    localparam logic [SW-1:0] S_MID  = SW'(MID_SAMPLE);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   tick;
    rx_state_e              state, state_n;
    logic [SW-1:0]          s;
    logic [2:0]             bit_idx;
    logic [7:0]             data_r;
    logic                   v0, v1, vote;
    logic [2:0]             cfg_last;
    logic                   cfg_pen, cfg_podd, cfg_stop2;
    logic                   second, par_err_p, armed;
    logic                   at_mid, at_last, complete;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .pclk     (pclk),
        .areset   (areset),
        .baud_div (baud_div),
        .tick     (tick)
    );

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            sync  <= '1;
            armed <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
            if (rx_s) armed <= 1'b1;
        end
    end

    assign rx_s     = sync[SYNC_STAGES-1];
    assign vote     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign at_mid   = tick && (s == S_MID);
    assign at_last  = tick && (s == S_LAST);
    // A low stop bit ends the frame early; otherwise the last stop bit does
    assign complete = at_mid && (state == STOP) &&
                      (!vote || !cfg_stop2 || second);

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:       if (tick && armed && !rx_s) state_n = START;
            START:      if (at_mid && vote)     state_n = IDLE;
                        else if (at_last)       state_n = DATA;
            DATA:       if (at_last && bit_idx == cfg_last)
                            state_n = cfg_pen ? PARITY : STOP;
            PARITY:     if (at_last)            state_n = STOP;
            STOP:       if (complete)           state_n = vote ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (tick && rx_s)       state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            s         <= '0;
            bit_idx   <= '0;
            data_r    <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            second    <= 1'b0;
            par_err_p <= 1'b0;
            cfg_last  <= '0;
            cfg_pen   <= 1'b0;
            cfg_podd  <= 1'b0;
            cfg_stop2 <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cfg_last  <= last_bit_idx(data_bits);
                cfg_pen   <= parity_en;
                cfg_podd  <= parity_odd;
                cfg_stop2 <= stop2;
            end
            if (tick) begin
                if (state == IDLE) begin
                    s         <= '0;
                    bit_idx   <= '0;
                    data_r    <= '0;
                    second    <= 1'b0;
                    par_err_p <= 1'b0;
                end else begin
                    s <= s + 1'b1;
                end
                if (s == S_V0) v0 <= rx_s;
                if (s == S_V1) v1 <= rx_s;
                if (state == DATA && s == S_MID)   data_r[bit_idx] <= vote;
                if (state == DATA && s == S_LAST)  bit_idx <= bit_idx + 3'd1;
                if (state == PARITY && s == S_MID) par_err_p <= (vote ^ (^data_r)) != cfg_podd;
                if (state == STOP && s == S_LAST)  second <= 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete && (!rx_valid || rx_ready)) begin
                rx_data    <= data_r;
                parity_err <= par_err_p;
                frame_err  <= !vote;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (complete && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (err_clr)                      overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames plus
// randomized frame formats against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

    logic        pclk = 1'b0;
    logic        areset = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  data_bits = 2'd3;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        rx_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, parity_err, frame_err, overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    uart_rx_deserializer dut (
        .pclk       (pclk),
        .areset     (areset),
        .rx         (rx),
        .baud_div   (baud_div),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bit_t();
        return 16 * (int'(baud_div) + 1);
    endfunction

    task automatic hold(input logic v, input int nb);
        rx = v;
        repeat (nb * bit_t()) @(negedge pclk);
    endtask

    task automatic send(input logic [7:0] d, input logic pbit,
                        input logic st1, input logic st2);
        int nb;
        nb = 5 + int'(data_bits);
        hold(1'b0, 1);
        for (int i = 0; i < nb; i++) hold(d[i], 1);
        if (parity_en) hold(pbit, 1);
        hold(st1, 1);
        if (stop2) hold(st2, 1);
        rx = 1'b1;
    endtask

    function automatic logic good_pbit(input logic [7:0] d);
        logic [7:0] m;
        m = d & 8'((1 << (5 + int'(data_bits))) - 1);
        return (^m) ^ parity_odd;
    endfunction

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    endtask

    task automatic expect_fields(input string tag, input logic [7:0] d,
                                 input logic pbit, input logic st1, input logic st2);
        int nb;
        logic [7:0] m;
        logic pe, fe;
        nb = 5 + int'(data_bits);
        m  = d & 8'((1 << nb) - 1);
        pe = parity_en && (((^m) ^ pbit) != parity_odd);
        fe = !st1 || (stop2 && !st2);
        wait_valid(tag, 4 * bit_t());
        chk({tag, "_data"}, 32'(rx_data), 32'(m));
        chk({tag, "_perr"}, 32'(parity_err), 32'(pe));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(fe));
    endtask

    task automatic accept(input string tag);
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
        chk({tag, "_drop"}, 32'(rx_valid), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d,
                               input logic pbit, input logic st1, input logic st2);
        expect_fields(tag, d, pbit, st1, st2);
        accept(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, lo, hi;
        logic [7:0] d;
        logic pb, s1, s2;

        repeat (3) @(negedge pclk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        areset = 1'b0;
        repeat (4) @(negedge pclk);

        // 0x55 8N1, latency window from start edge, then a 5-cycle hold
        baud_div = 16'd3; data_bits = 2'd3; parity_en = 0; stop2 = 0;
        lat = 0;
        fork
            send(8'h55, 1'b0, 1'b1, 1'b1);
            begin
                while (!rx_valid && lat < 2000) begin
                    @(negedge pclk);
                    lat++;
                end
            end
        join
        lo = 3 + 10 * 4 + 9 * 64;
        hi = 2 + 11 * 4 + 9 * 64;
        chk("lat_55", 32'((lat >= lo && lat <= hi) ? lo : lat), 32'(lo));
        expect_fields("f55", 8'h55, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("hold_data", 32'(rx_data), 32'h55);
            chk("hold_valid", 32'(rx_valid), 32'd1);
        end
        accept("f55");
        hold(1'b1, 1);

        // 0xA3 8E1 with correct and wrong parity
        parity_en = 1; parity_odd = 0;
        send(8'hA3, 1'b0, 1'b1, 1'b1);
        check_frame("a3_ok", 8'hA3, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 1);
        send(8'hA3, 1'b1, 1'b1, 1'b1);
        check_frame("a3_bad", 8'hA3, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 1);

        // 0x1F 5N2, second stop low, line held low afterwards
        parity_en = 0; data_bits = 2'd0; stop2 = 1;
        send(8'h1F, 1'b0, 1'b1, 1'b0);
        fork
            hold(1'b0, 3);
            check_frame("b5n2", 8'h1F, 1'b0, 1'b1, 1'b0);
        join
        chk("brk_quiet", 32'(rx_valid), 32'd0);
        hold(1'b1, 1);
        chk("brk_idle", 32'(rx_valid), 32'd0);

        // 4-tick low glitch is a false start
        data_bits = 2'd3; stop2 = 0;
        rx = 1'b0;
        repeat (4 * (int'(baud_div) + 1)) @(negedge pclk);
        hold(1'b1, 3);
        chk("glitch", 32'(rx_valid), 32'd0);
        send(8'h5A, 1'b0, 1'b1, 1'b1);
        check_frame("post_glitch", 8'h5A, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 1);

        // Overrun with consumer stalled, then err_clr
        send(8'h11, 1'b0, 1'b1, 1'b1);
        send(8'h22, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 1);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        err_clr = 1'b1;
        @(negedge pclk);
        err_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        chk("ovr_keep", 32'(rx_data), 32'h11);
        accept("ovr");

        // Reset mid-DATA with a byte pending, then a clean frame
        send(8'h77, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 1);
        fork
            send(8'h3C, 1'b0, 1'b1, 1'b1);
            begin
                repeat (3 * bit_t() + 5) @(negedge pclk);
                #2 areset = 1'b1;
                #1;
                chk("mid_rst_valid", 32'(rx_valid), 32'd0);
                chk("mid_rst_data", 32'(rx_data), 32'd0);
            end
        join
        @(negedge pclk);
        areset = 1'b0;
        hold(1'b1, 1);
        chk("rst_noframe", 32'(rx_valid), 32'd0);
        send(8'h3C, 1'b0, 1'b1, 1'b1);
        check_frame("post_rst", 8'h3C, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 1);

        // Randomized frame formats, data, parity and stop errors
        for (int k = 0; k < 30; k++) begin
            baud_div   = 16'($urandom_range(0, 3));
            data_bits  = 2'($urandom_range(0, 3));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            stop2      = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            pb = good_pbit(d) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            hold(1'b1, 1);
            send(d, pb, s1, s2);
            check_frame("rnd", d, pb, s1, s2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
